// File: rtl/dyt_fetch_unit.sv
// dyt_fetch_unit: instruction fetch front end feeding decode from the LSU
// instruction port. One read outstanding at a time; returned words are
// buffered in a small {pc, word} FIFO drained over valid/ready.
// Optional feature macro: DYT_FETCH_MISALIGN_EXC_EN (misaligned-redirect
// exception with a HALT state). Without it, redirect targets are forced to
// word alignment and the exception outputs are tied low.
module dyt_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_i_ren,
    output logic [31:0] mem_i_addr,
    input  logic        mem_i_gnt,
    input  logic [31:0] mem_r_data,
    input  logic        redirect_vld,
    input  logic [31:0] redirect_pc,
    output logic        instr_vld,
    input  logic        instr_rdy,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_exc,
    output logic [31:0] exc_pc
);

    localparam int            PW      = $clog2(QUEUE_DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

`ifdef DYT_FETCH_MISALIGN_EXC_EN
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1} state_t;
`endif

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, req_addr;
    logic          squash;
    logic [31:0]   pc_q   [QUEUE_DEPTH];
    logic [31:0]   word_q [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          gnt_ok, push, pop, issue, take_issue, halted;
    logic [31:0]   rdr_pc;

`ifdef DYT_FETCH_MISALIGN_EXC_EN
    logic        rdr_bad, halt_nxt, fetch_exc_q;
    logic [31:0] exc_pc_q;

    assign rdr_pc    = redirect_pc;
    assign rdr_bad   = |redirect_pc[1:0];
    assign halt_nxt  = redirect_vld ? rdr_bad : fetch_exc_q;
    assign halted    = fetch_exc_q;
    assign fetch_exc = fetch_exc_q;
    assign exc_pc    = exc_pc_q;

    // Exception latch: every redirect re-evaluates it; only a misaligned one
    // records the faulting target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_exc_q <= 1'b0;
            exc_pc_q    <= '0;
        end else if (redirect_vld) begin
            fetch_exc_q <= rdr_bad;
            if (rdr_bad) exc_pc_q <= redirect_pc;
        end
    end
`else
    logic [1:0] unused_rdr_lo;

    assign unused_rdr_lo = redirect_pc[1:0];
    assign rdr_pc        = {redirect_pc[31:2], 2'b00};
    assign halted        = 1'b0;
    assign fetch_exc     = 1'b0;
    assign exc_pc        = '0;
`endif

    assign mem_i_ren  = (state == REQ);
    assign mem_i_addr = req_addr;
    assign instr_vld  = (count != '0);
    assign instr      = word_q[rd_ptr];
    assign instr_pc   = pc_q[rd_ptr];

    // A redirect voids both the push and the pop of its cycle.
    assign gnt_ok = (state == REQ) && mem_i_gnt;
    assign push   = gnt_ok && !squash && !redirect_vld;
    assign pop    = instr_vld && instr_rdy && !redirect_vld;

    // Occupancy after this cycle's push/pop; reissue decisions look at it.
    always_comb begin
        count_nxt = count;
        if (redirect_vld) count_nxt = '0;
        else              count_nxt = count + CW'(push) - CW'(pop);
    end

    // A new request may start only when a slot is guaranteed at grant time.
    assign issue      = !halted && (count_nxt < DEPTH_C) && !redirect_vld;
    assign take_issue = issue && ((state != REQ) || mem_i_gnt);

    // Next-state: REQ holds until granted, then reissues or parks.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue) state_nxt = REQ;
`ifdef DYT_FETCH_MISALIGN_EXC_EN
                else if (halt_nxt) state_nxt = HALT;
`endif
            end
            REQ: begin
                if (mem_i_gnt) begin
                    if (issue) state_nxt = REQ;
`ifdef DYT_FETCH_MISALIGN_EXC_EN
                    else if (halt_nxt) state_nxt = HALT;
`endif
                    else state_nxt = IDLE;
                end
            end
`ifdef DYT_FETCH_MISALIGN_EXC_EN
            HALT: begin
                if (issue) state_nxt = REQ;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // PC tracking: redirect retargets, an issue latches the request address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else if (redirect_vld) begin
            fetch_pc <= rdr_pc;
        end else if (take_issue) begin
            req_addr <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Squash marks an in-flight read whose data must be dropped at its grant;
    // req_addr stays frozen so the LSU can finish the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                squash <= 1'b0;
        else if (gnt_ok)                        squash <= 1'b0;
        else if (redirect_vld && state == REQ)  squash <= 1'b1;
    end

    // FIFO storage and pointers; outputs read straight from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                pc_q[i]   <= '0;
                word_q[i] <= '0;
            end
        end else if (redirect_vld) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_q[wr_ptr]   <= req_addr;
                word_q[wr_ptr] <= mem_r_data;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_dyt_fetch_unit.sv
// Bench for dyt_fetch_unit: LSU responder with configurable grant latency,
// a monitor comparing decode traffic to an expected sequential PC stream,
// and directed plus randomized scenarios.
module tb_dyt_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_i_ren, mem_i_gnt;
    logic [31:0] mem_i_addr, mem_r_data;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        instr_vld, instr_rdy;
    logic [31:0] instr, instr_pc;
    logic        fetch_exc;
    logic [31:0] exc_pc;

    int          total = 0;
    int          bad   = 0;
    int          ndeliv = 0;
    bit          mon_en = 0;
    logic [31:0] exp_pc;

    // LSU model knobs
    int lat      = 2;
    bit rand_lat = 0;
    bit spur_en  = 0;

    always #5 clk = ~clk;

    dyt_fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .mem_i_ren(mem_i_ren), .mem_i_addr(mem_i_addr),
        .mem_i_gnt(mem_i_gnt), .mem_r_data(mem_r_data),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
        .instr_vld(instr_vld), .instr_rdy(instr_rdy),
        .instr(instr), .instr_pc(instr_pc),
        .fetch_exc(fetch_exc), .exc_pc(exc_pc)
    );

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] wfun(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // LSU responder: grant arrives `lat` cycles after a request starts.
    int wcnt = 0, cur_lat = 2;
    bit started = 0;
    initial begin
        mem_i_gnt  = 1'b0;
        mem_r_data = '0;
    end
    always @(posedge clk) begin
        #1;
        if (rst || !mem_i_ren) begin
            wcnt = 0; started = 0;
            mem_i_gnt  = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_r_data = $urandom;
        end else begin
            if (!started || mem_i_gnt) begin
                wcnt = 0;
                cur_lat = rand_lat ? int'($urandom_range(0, 4)) : lat;
            end else wcnt++;
            started = 1;
            mem_i_gnt  = (wcnt == cur_lat);
            mem_r_data = mem_i_gnt ? wfun(mem_i_addr) : $urandom;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect_vld = 1'b1; redirect_pc = t;
        tick();
        redirect_vld = 1'b0;
    endtask

    // Wait for the next accepted instruction; returns cycles waited.
    task automatic wait_deliv(output bit ok, output logic [31:0] pc,
                              output logic [31:0] w, output int cyc);
        ok = 0; pc = '0; w = '0; cyc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (instr_vld && instr_rdy && !redirect_vld) begin
                ok = 1; pc = instr_pc; w = instr; cyc = c; break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_gnt(output bit ok, output logic [31:0] ga);
        ok = 0; ga = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_i_ren && mem_i_gnt) begin ok = 1; ga = mem_i_addr; break; end
        end
        @(posedge clk); #1;
    endtask

    // Monitor: sequential PC stream restarting at each redirect target,
    // flush after redirect, and request stability until grant.
    task automatic monitor();
        bit p_ren = 0, p_gnt = 0, p_rdr = 0;
        logic [31:0] p_addr = '0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (p_rdr) begin
                    total++;
                    if (instr_vld !== 1'b0) begin
                        bad++; $display("FAIL mon_flush: instr_vld=%b want 0", instr_vld);
                    end
                end
                if (p_ren && !p_gnt) begin
                    total++;
                    if (mem_i_ren !== 1'b1 || mem_i_addr !== p_addr) begin
                        bad++;
                        $display("FAIL mon_req_stable: ren=%b addr=%h want ren=1 addr=%h",
                                 mem_i_ren, mem_i_addr, p_addr);
                    end
                end
                if (redirect_vld) begin
`ifdef DYT_FETCH_MISALIGN_EXC_EN
                    exp_pc = redirect_pc;
`else
                    exp_pc = {redirect_pc[31:2], 2'b00};
`endif
                end else if (instr_vld && instr_rdy) begin
                    total++;
                    if (instr_pc !== exp_pc || instr !== wfun(exp_pc)) begin
                        bad++;
                        $display("FAIL mon_deliv: pc=%h word=%h want pc=%h word=%h",
                                 instr_pc, instr, exp_pc, wfun(exp_pc));
                    end
                    exp_pc = exp_pc + 32'd4;
                    ndeliv++;
                end
                p_ren = mem_i_ren; p_gnt = mem_i_gnt; p_addr = mem_i_addr; p_rdr = redirect_vld;
            end else begin
                p_ren = 0; p_rdr = 0;
            end
        end
    endtask

    task automatic test_reset();
        int i;
        rst = 1'b1; redirect_vld = 1'b0; redirect_pc = '0; instr_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (mem_i_ren !== 1'b0) begin bad++; $display("FAIL rst_ren: %b want 0", mem_i_ren); end
        total++; if (mem_i_addr !== RPC) begin bad++; $display("FAIL rst_addr: %h want %h", mem_i_addr, RPC); end
        total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL rst_vld: %b want 0", instr_vld); end
        total++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin
            bad++; $display("FAIL rst_instr: instr=%h pc=%h want 0 0", instr, instr_pc); end
        total++; if (fetch_exc !== 1'b0 || exc_pc !== 32'h0) begin
            bad++; $display("FAIL rst_exc: exc=%b exc_pc=%h want 0 0", fetch_exc, exc_pc); end
        exp_pc = RPC; mon_en = 1;
        rst = 1'b0;
        tick();
        total++; if (mem_i_ren !== 1'b1 || mem_i_addr !== RPC) begin
            bad++; $display("FAIL first_req: ren=%b addr=%h want 1 %h", mem_i_ren, mem_i_addr, RPC); end
        instr_rdy = 1'b1;
        for (i = 1; i <= 10; i++) begin
            tick();
            if (instr_vld) break;
        end
        total++; if (i != 3) begin bad++; $display("FAIL first_vld_latency: %0d edges want 3", i); end
    endtask

    task automatic test_stream();
        bit ok; logic [31:0] pc, w; int cyc;
        for (int k = 0; k < 3; k++) begin
            wait_deliv(ok, pc, w, cyc);
            total++;
            if (!ok || pc !== RPC + 32'(4 * k) || w !== wfun(RPC + 32'(4 * k))) begin
                bad++; $display("FAIL stream_%0d: ok=%0d pc=%h word=%h want pc=%h", k, ok, pc, w, RPC + 32'(4 * k));
            end
            if (k > 0) begin
                total++;
                if (cyc != 2) begin bad++; $display("FAIL stream_cadence_%0d: waited %0d want 2", k, cyc); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pc0;
        instr_rdy = 1'b0;
        repeat (20) tick();
        total++; if (mem_i_ren !== 1'b0 || instr_vld !== 1'b1) begin
            bad++; $display("FAIL bp_full: ren=%b vld=%b want 0 1", mem_i_ren, instr_vld); end
        pc0 = instr_pc;
        instr_rdy = 1'b1; tick(); instr_rdy = 1'b0;
        total++; if (mem_i_ren !== 1'b1 || instr_vld !== 1'b1 || instr_pc !== pc0 + 32'd4) begin
            bad++; $display("FAIL bp_pop1: ren=%b vld=%b pc=%h want 1 1 %h", mem_i_ren, instr_vld, instr_pc, pc0 + 32'd4); end
        instr_rdy = 1'b1; tick(); instr_rdy = 1'b0;
        total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL bp_pop2: vld=%b want 0", instr_vld); end
        instr_rdy = 1'b1;
    endtask

    task automatic test_redirect_squash();
        bit ok; logic [31:0] a, ga, pc, w; int cyc;
        wait_gnt(ok, ga);
        tick();
        a = mem_i_addr;
        total++; if (!ok || mem_i_ren !== 1'b1) begin bad++; $display("FAIL sq_setup: ok=%0d ren=%b want 1 1", ok, mem_i_ren); end
        do_redirect(32'h400);
        wait_gnt(ok, ga);
        total++; if (!ok || ga !== a) begin bad++; $display("FAIL sq_hold_addr: ok=%0d addr=%h want %h", ok, ga, a); end
        total++; if (mem_i_ren !== 1'b1 || mem_i_addr !== 32'h400) begin
            bad++; $display("FAIL sq_next_req: ren=%b addr=%h want 1 00000400", mem_i_ren, mem_i_addr); end
        wait_deliv(ok, pc, w, cyc);
        total++; if (!ok || pc !== 32'h400) begin bad++; $display("FAIL sq_first_pc: pc=%h want 00000400", pc); end
    endtask

    task automatic test_redirect_gnt();
        bit ok; logic [31:0] ga, pc, w; int cyc;
        wait_gnt(ok, ga);
        tick(); tick();
        do_redirect(32'h500);
        total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL rg_flush: vld=%b want 0", instr_vld); end
        wait_deliv(ok, pc, w, cyc);
        total++; if (!ok || pc !== 32'h500) begin bad++; $display("FAIL rg_first_pc: pc=%h want 00000500", pc); end
    endtask

    task automatic test_redirect_pop();
        bit ok; logic [31:0] pc, w; int cyc;
        instr_rdy = 1'b0;
        for (int c = 0; c < 20; c++) begin @(negedge clk); if (instr_vld) break; end
        @(posedge clk); #1;
        instr_rdy = 1'b1;
        do_redirect(32'h600);
        total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL rp_flush: vld=%b want 0", instr_vld); end
        wait_deliv(ok, pc, w, cyc);
        total++; if (!ok || pc !== 32'h600) begin bad++; $display("FAIL rp_first_pc: pc=%h want 00000600", pc); end
    endtask

    task automatic test_wrap();
        bit ok; logic [31:0] pc, w, e; int cyc;
        do_redirect(32'hFFFF_FFFC);
        for (int k = 0; k < 3; k++) begin
            e = 32'hFFFF_FFFC + 32'(4 * k);
            wait_deliv(ok, pc, w, cyc);
            total++; if (!ok || pc !== e || w !== wfun(e)) begin
                bad++; $display("FAIL wrap_%0d: pc=%h word=%h want pc=%h", k, pc, w, e); end
        end
    endtask

    task automatic test_misalign();
        bit ok; logic [31:0] pc, w; int cyc;
        do_redirect(32'h202);
`ifdef DYT_FETCH_MISALIGN_EXC_EN
        repeat (15) tick();
        total++; if (fetch_exc !== 1'b1 || exc_pc !== 32'h202) begin
            bad++; $display("FAIL mis_exc: exc=%b exc_pc=%h want 1 00000202", fetch_exc, exc_pc); end
        total++; if (mem_i_ren !== 1'b0 || instr_vld !== 1'b0) begin
            bad++; $display("FAIL mis_halt: ren=%b vld=%b want 0 0", mem_i_ren, instr_vld); end
        do_redirect(32'h300);
        total++; if (fetch_exc !== 1'b0) begin bad++; $display("FAIL mis_clear: exc=%b want 0", fetch_exc); end
        wait_deliv(ok, pc, w, cyc);
        total++; if (!ok || pc !== 32'h300) begin bad++; $display("FAIL mis_resume: pc=%h want 00000300", pc); end
`else
        wait_deliv(ok, pc, w, cyc);
        total++; if (!ok || pc !== 32'h200 || w !== wfun(32'h200)) begin
            bad++; $display("FAIL mis_align: pc=%h word=%h want 00000200 %h", pc, w, wfun(32'h200)); end
        total++; if (fetch_exc !== 1'b0 || exc_pc !== 32'h0) begin
            bad++; $display("FAIL mis_tied: exc=%b exc_pc=%h want 0 0", fetch_exc, exc_pc); end
`endif
    endtask

    task automatic test_random();
        int n0;
        n0 = ndeliv;
        rand_lat = 1; spur_en = 1;
        for (int c = 0; c < 1500; c++) begin
            instr_rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 39) == 0) begin
                redirect_vld = 1'b1;
`ifdef DYT_FETCH_MISALIGN_EXC_EN
                redirect_pc = $urandom & 32'h0000_0FFC;
`else
                redirect_pc = $urandom & 32'h0000_0FFF;
`endif
            end else redirect_vld = 1'b0;
            tick();
        end
        redirect_vld = 1'b0; rand_lat = 0; spur_en = 0; instr_rdy = 1'b1;
        repeat (10) tick();
        total++; if (ndeliv - n0 < 50) begin bad++; $display("FAIL rand_progress: %0d deliveries want >=50", ndeliv - n0); end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork monitor(); join_none
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_squash();
        test_redirect_gnt();
        test_redirect_pop();
        test_wrap();
        test_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
